// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO helpers: clog2 function and depth limits
package fifo_pkg;

    localparam int FIFO_DP_MIN = 2;
    localparam int FIFO_DP_MAX = 256;

    // Smallest n with 2**n >= value; used to size pointers and level counters.
    function automatic int fifo_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - W x DP register array, one write port, one asynchronous read port
module sync_fifo_mem #(
    parameter int W  = 8,
    parameter int DP = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:DP-1];

    // Storage is deliberately not reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_th.sv
// rtl/sync_fifo_th.sv - single-clock FIFO with thresholds, exact level, flush and sticky errors
module sync_fifo_th
    import fifo_pkg::*;
#(
    parameter int W       = 8,
    parameter int DP      = 4,
    parameter bit RD_FAST = 1'b1,
    parameter int AW      = fifo_clog2(DP),
    parameter int CW      = fifo_clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    input  logic [CW-1:0] afull_th,
    input  logic [CW-1:0] aempty_th,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic [CW-1:0] level,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW-1:0] PTR_LAST = AW'(DP - 1);
    localparam logic [CW-1:0] LVL_FULL = CW'(DP);

    if ((DP < FIFO_DP_MIN) || (DP > FIFO_DP_MAX)) begin : g_dp_check
        $error("sync_fifo_th: DP=%0d outside supported range", DP);
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;
    logic          rd_commit;
    logic          wr_commit;
    logic [W-1:0]  mem_rd_data;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc    = rd_en & (level != '0);
    assign wr_acc    = wr_en & ((level != LVL_FULL) | rd_acc);
    assign rd_commit = rd_acc & ~flush;
    assign wr_commit = wr_acc & ~flush;

    assign full   = (level == LVL_FULL);
    assign empty  = (level == '0);
    assign afull  = (level >= afull_th);
    assign aempty = (level <= aempty_th);

    sync_fifo_mem #(
        .W  (W),
        .DP (DP),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_commit),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_commit) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (rd_commit) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
        end
    end

    // Exact fill level; a simultaneous read and write leave it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case ({wr_commit, rd_commit})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags; requests in a flush cycle are discarded silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc) begin
                ovf <= 1'b1;
            end
            if (rd_en & ~rd_acc) begin
                udf <= 1'b1;
            end
        end
    end

    if (RD_FAST) begin : g_rd_fast
        assign rd_data = mem_rd_data;
    end else begin : g_rd_reg
        logic [W-1:0] rd_data_q;

        // Registered read data; holds across flush and idle cycles.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_data_q <= '0;
            end else if (rd_commit) begin
                rd_data_q <= mem_rd_data;
            end
        end

        assign rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_th.sv
// tb/tb_sync_fifo_th.sv - directed scoreboard bench, DP=5 in fall-through and registered modes
module tb_sync_fifo_th;

    localparam int W  = 8;
    localparam int DP = 5;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [CW-1:0] afull_th;
    logic [CW-1:0] aempty_th;

    logic [W-1:0]  f_rd_data, s_rd_data;
    logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [CW-1:0] f_level, s_level;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];
    int           m_level;
    logic         m_ovf;
    logic         m_udf;

    sync_fifo_th #(.W(W), .DP(DP), .RD_FAST(1'b1)) u_fast (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (f_rd_data),
        .afull_th  (afull_th),
        .aempty_th (aempty_th),
        .full      (f_full),
        .empty     (f_empty),
        .afull     (f_afull),
        .aempty    (f_aempty),
        .level     (f_level),
        .ovf       (f_ovf),
        .udf       (f_udf)
    );

    sync_fifo_th #(.W(W), .DP(DP), .RD_FAST(1'b0)) u_slow (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (s_rd_data),
        .afull_th  (afull_th),
        .aempty_th (aempty_th),
        .full      (s_full),
        .empty     (s_empty),
        .afull     (s_afull),
        .aempty    (s_aempty),
        .level     (s_level),
        .ovf       (s_ovf),
        .udf       (s_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic e_full, e_empty, e_afull, e_aempty;
        e_full   = (m_level == DP);
        e_empty  = (m_level == 0);
        e_afull  = (m_level >= int'(afull_th));
        e_aempty = (m_level <= int'(aempty_th));
        chk({tag, " f.level"},  32'(f_level),  32'(m_level));
        chk({tag, " s.level"},  32'(s_level),  32'(m_level));
        chk({tag, " f.full"},   32'(f_full),   32'(e_full));
        chk({tag, " s.full"},   32'(s_full),   32'(e_full));
        chk({tag, " f.empty"},  32'(f_empty),  32'(e_empty));
        chk({tag, " s.empty"},  32'(s_empty),  32'(e_empty));
        chk({tag, " f.afull"},  32'(f_afull),  32'(e_afull));
        chk({tag, " s.afull"},  32'(s_afull),  32'(e_afull));
        chk({tag, " f.aempty"}, 32'(f_aempty), 32'(e_aempty));
        chk({tag, " s.aempty"}, 32'(s_aempty), 32'(e_aempty));
        chk({tag, " f.ovf"},    32'(f_ovf),    32'(m_ovf));
        chk({tag, " s.ovf"},    32'(s_ovf),    32'(m_ovf));
        chk({tag, " f.udf"},    32'(f_udf),    32'(m_udf));
        chk({tag, " s.udf"},    32'(s_udf),    32'(m_udf));
    endtask

    // One clock of traffic, entered just after a falling edge.
    task automatic step(input string tag, input logic w, input logic [W-1:0] d, input logic r);
        logic         racc, wacc;
        logic [W-1:0] e;
        e       = '0;
        flush   = 1'b0;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        #1;
        racc = r && (m_level != 0);
        wacc = w && ((m_level != DP) || racc);
        if (racc) begin
            e = sb_q.pop_front();
            chk({tag, " fwft rd_data"}, 32'(f_rd_data), 32'(e));
        end
        if (wacc) sb_q.push_back(d);
        if (r && !racc) m_udf = 1'b1;
        if (w && !wacc) m_ovf = 1'b1;
        if (wacc && !racc) m_level++;
        if (racc && !wacc) m_level--;
        @(posedge clk);
        #1;
        if (racc) chk({tag, " reg rd_data"}, 32'(s_rd_data), 32'(e));
        check_state(tag);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held;
        reset_n   = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_data   = '0;
        afull_th  = 3'd3;
        aempty_th = 3'd1;
        m_level   = 0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_state("reset");
        chk("reset reg rd_data", 32'(s_rd_data), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill to full, walking the thresholds, then overflow.
        for (int i = 0; i < DP; i++) step("fill", 1'b1, 8'hA0 + 8'(i), 1'b0);
        step("overflow", 1'b1, 8'hAF, 1'b0);

        afull_th = 3'd6;
        #1;
        chk("afull_th=6 f.afull", 32'(f_afull), 32'h0);
        chk("afull_th=6 s.afull", 32'(s_afull), 32'h0);
        afull_th = 3'd3;
        @(negedge clk);

        // Write and read together while full.
        step("full wr+rd", 1'b1, 8'hA5, 1'b1);

        // Simultaneous traffic carries both pointers across the wrap.
        for (int i = 0; i < 12; i++) step("wrap", 1'b1, 8'hB0 + 8'(i), 1'b1);

        // Drain to empty, checking order and thresholds on the way down.
        for (int i = 0; i < DP; i++) step("drain", 1'b0, 8'h00, 1'b1);

        // Empty with write and read together: read refused, write accepted.
        step("empty wr+rd", 1'b1, 8'hC0, 1'b1);
        #1;
        chk("fwft next cycle", 32'(f_rd_data), 32'hC0);
        @(negedge clk);
        step("read C0", 1'b0, 8'h00, 1'b1);
        held = 8'hC0;

        // Flush at level 3 with requests pending.
        for (int i = 0; i < 3; i++) step("prefill", 1'b1, 8'hD0 + 8'(i), 1'b0);
        flush   = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'hEE;
        @(posedge clk);
        #1;
        m_level = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        sb_q.delete();
        check_state("flush");
        chk("flush reg rd_data held", 32'(s_rd_data), 32'(held));
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Post-flush traffic then asynchronous reset between edges.
        step("refill", 1'b1, 8'hE1, 1'b0);
        step("refill", 1'b1, 8'hE2, 1'b0);
        step("read E1", 1'b0, 8'h00, 1'b1);
        #2;
        reset_n  = 1'b0;
        afull_th = 3'd0;
        #1;
        m_level = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        sb_q.delete();
        check_state("async reset");
        chk("async reset reg rd_data", 32'(s_rd_data), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
